// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - opcodes, command-word field positions and halt FSM states for cmd_dispatch
package cmd_pkg;

  localparam int CMD_W    = 64;
  localparam int OPC_MSB  = 63;
  localparam int OPC_LSB  = 56;
  localparam int CORE_MSB = 55;
  localparam int CORE_LSB = 48;

  localparam logic [7:0] OP_HALT  = 8'h00;
  localparam logic [7:0] OP_NTT   = 8'h01;
  localparam logic [7:0] OP_DMA   = 8'h02;
  localparam logic [7:0] OP_FENCE = 8'h03;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } halt_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous in-order FIFO with combinational head; DEPTH must be a power of two
module cmd_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; clearing the pointers is enough to discard contents.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_FULL);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/cmd_dispatch.sv
// rtl/cmd_dispatch.sv - buffered in-order command front-end issuing NTT/DMA start pulses with fence and halt-drain
// Optional CMD_DISPATCH_PERF_EN adds perf_dispatched/perf_stall counters.
module cmd_dispatch
  import cmd_pkg::*;
#(
  parameter int NUM_CORES  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [CMD_W-1:0]     cmd_data,
  output logic                 cmd_ready,
  output logic [NUM_CORES-1:0] core_start,
  input  logic [NUM_CORES-1:0] core_ready,
  output logic                 dma_start,
  input  logic                 dma_ready,
  output logic                 halted,
  output logic                 err_illegal
`ifdef CMD_DISPATCH_PERF_EN
  ,
  output logic [31:0]          perf_dispatched,
  output logic [31:0]          perf_stall
`endif
);

  halt_state_e          r_state;
  halt_state_e          w_state_nxt;
  logic                 r_halt_accepted;
  logic [NUM_CORES-1:0] r_core_start;
  logic                 r_dma_start;
  logic                 r_err_illegal;

  logic                 w_push;
  logic [CMD_W-1:0]     w_head;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_head_valid;
  logic [7:0]           w_opc;
  logic [7:0]           w_core_idx;
  logic [NUM_CORES-1:0] w_core_sel;
  logic                 w_core_ok;
  logic                 w_core_avail;
  logic                 w_engines_idle;
  logic                 w_pop;
  logic [NUM_CORES-1:0] w_core_start_nxt;
  logic                 w_dma_start_nxt;
  logic                 w_err_set;

  assign cmd_ready = !w_full && !r_halt_accepted;
  assign w_push    = cmd_valid && cmd_ready;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (cmd_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_valid = !w_empty;
  assign w_opc        = w_head[OPC_MSB:OPC_LSB];
  assign w_core_idx   = w_head[CORE_MSB:CORE_LSB];
  assign w_core_ok    = (w_core_idx < 8'(NUM_CORES));

  always_comb begin
    w_core_sel = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_core_sel[i] = (w_core_idx == 8'(i));
    end
  end

  // Last cycle's start pulses mask engines whose ready has not dropped yet.
  assign w_core_avail   = |(w_core_sel & core_ready & ~r_core_start);
  assign w_engines_idle = (&core_ready) && dma_ready && !(|r_core_start) && !r_dma_start;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (w_head_valid && (w_opc == OP_HALT)) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_engines_idle) w_state_nxt = ST_HALTED;
      ST_HALTED: w_state_nxt = ST_HALTED;
      default:   w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_pop            = 1'b0;
    w_core_start_nxt = '0;
    w_dma_start_nxt  = 1'b0;
    w_err_set        = 1'b0;
    if ((r_state == ST_RUN) && w_head_valid) begin
      case (w_opc)
        OP_HALT: w_pop = 1'b1;
        OP_NTT: begin
          if (!w_core_ok) begin
            w_pop     = 1'b1;
            w_err_set = 1'b1;
          end else if (w_core_avail) begin
            w_pop            = 1'b1;
            w_core_start_nxt = w_core_sel;
          end
        end
        OP_DMA: begin
          if (dma_ready && !r_dma_start) begin
            w_pop           = 1'b1;
            w_dma_start_nxt = 1'b1;
          end
        end
        OP_FENCE: w_pop = w_engines_idle;
        default: begin
          w_pop     = 1'b1;
          w_err_set = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_halt_accepted <= 1'b0;
      r_core_start    <= '0;
      r_dma_start     <= 1'b0;
      r_err_illegal   <= 1'b0;
    end else begin
      if (w_push && (cmd_data[OPC_MSB:OPC_LSB] == OP_HALT)) r_halt_accepted <= 1'b1;
      r_core_start  <= w_core_start_nxt;
      r_dma_start   <= w_dma_start_nxt;
      r_err_illegal <= r_err_illegal | w_err_set;
    end
  end

  assign core_start  = r_core_start;
  assign dma_start   = r_dma_start;
  assign err_illegal = r_err_illegal;
  assign halted      = (r_state == ST_HALTED);

`ifdef CMD_DISPATCH_PERF_EN
  logic [31:0] r_perf_dispatched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_dispatched <= '0;
      r_perf_stall      <= '0;
    end else begin
      if ((|w_core_start_nxt) || w_dma_start_nxt) r_perf_dispatched <= r_perf_dispatched + 32'd1;
      if (w_head_valid && !w_pop) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_dispatched = r_perf_dispatched;
  assign perf_stall      = r_perf_stall;
`endif

endmodule

// File: doc/cmd_dispatch.md
# cmd_dispatch

Parametrised command front-end for the FHE accelerator: accepts 64-bit host commands through a valid/ready port and buffers them in an in-order FIFO. It dispatches one-cycle start pulses to NUM_CORES NTT cores and one DMA engine, and supports fence and halt with drain. It replaces the fixed two-core, unbuffered command path and adds busy tracking, illegal-command detection and back-pressure.

## Interface
- NUM_CORES, 2, number of NTT cores (1..16)
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  host command valid
- cmd_data  in  64  command word: [63:56] opcode, [55:48] core index, rest reserved
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- core_start  out  NUM_CORES  one-cycle start pulse per core
- core_ready  in  NUM_CORES  core idle
- dma_start  out  1  one-cycle DMA start pulse
- dma_ready  in  1  DMA idle
- halted  out  1  sticky; set after HALT has drained
- err_illegal  out  1  sticky; illegal command seen

## Operation
- Opcodes: 00 HALT, 01 NTT (target core = cmd_data[55:48]), 02 DMA, 03 FENCE; all others illegal.
- Accepted commands enter the FIFO. The head is processed strictly in order.
- NTT:
  - Dispatched when the target core is ready and was not started in the previous cycle. That previous-cycle mask exists because a core's ready drops one cycle after start.
  - Otherwise the head stalls and blocks younger commands.
- DMA: same rule against dma_ready.
- FENCE: popped only when every engine is ready and no start pulse was issued in the previous cycle. Produces no pulse.
- HALT:
  - Popped immediately. Sets halt_pending, and no further commands are dispatched.
  - halted is set once all engines are ready and no start was issued in the previous cycle.
  - halted stays set until rst.
- Illegal opcode, or NTT with core index ≥ NUM_CORES: popped without a pulse, and err_illegal is set (sticky until rst).
- cmd_ready = !fifo_full && !halt_accepted. halt_accepted is set the cycle a HALT word is written into the FIFO, so nothing after HALT is ever accepted.
- Reserved bits are ignored.

## Timing
- Reset values: cmd_ready=1 (once out of reset), core_start=0, dma_start=0, halted=0, err_illegal=0. FIFO is empty; halt_pending and halt_accepted are clear.
- Reset mid-operation discards FIFO contents. Start pulses already issued are not retracted.
- Accept at edge t → head valid in cycle t+1 → start pulse registered, high during cycle t+2 (2-cycle latency, idle engine).
- At most one command is popped per cycle, so at most one start pulse per cycle.
- Sustained rate to distinct idle engines: 1 command/cycle. The same engine is re-dispatched no sooner than its ready permits.
- Push and pop in the same cycle are legal, including when full: cmd_ready is low when full, so no push occurs while full. Pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
- halted rises no earlier than 1 cycle after the HALT pop.

## Configuration
- CMD_DISPATCH_PERF_EN defined: adds output perf_dispatched[31:0] and output perf_stall[31:0].
  - perf_dispatched counts start pulses.
  - perf_stall counts cycles with a valid head that is not popped.
  - Both reset to 0 and wrap at 2^32.
- Macro undefined: neither port nor counter exists, and the rest of the behaviour is identical.

## Structure
- Package cmd_pkg:
  - opcode constants OP_HALT, OP_NTT, OP_DMA, OP_FENCE
  - field positions: OPC_MSB/LSB, CORE_MSB/LSB
  - command-word width CMD_W=64
- Sub-module cmd_fifo: synchronous FIFO, parameters WIDTH and DEPTH, with push/pop/full/empty/head.
- Dispatch logic and halt/fence tracking stay in cmd_dispatch.

## Test plan
- NUM_CORES=4, send NTT core 2 with all ready → core_start=4'b0100 exactly 2 cycles after accept, one cycle wide.
- Hold core_ready[0]=0, send NTT core 0 then DMA → DMA pulse withheld until after core 0's pulse (in-order).
- Fill 4 commands with all engines busy → cmd_ready=0 after the 4th. Release one core → cmd_ready returns the cycle after the pop.
- Send DMA, FENCE, NTT core 1 with dma_ready low for 10 cycles after start → core_start[1] only after dma_ready returns.
- Send opcode 8'h7F, then NTT core 5 with NUM_CORES=4 → err_illegal=1, no pulses, FIFO drains.
- Send NTT core 0, HALT, DMA → DMA not accepted (cmd_ready=0). halted=1 only after core_ready[0] returns; assert rst → halted=0.
